// File: rtl/hi_flite_tx_if.sv
// hi_flite_tx_if: payload byte handshake between the ARM-side byte source
// and the FeliCa frame transmitter.
//   tx_data  : payload byte, length byte first, sent MSB first
//   tx_valid : tx_data/tx_last valid
//   tx_last  : marks the final payload byte of the frame
//   tx_ready : transmitter accepts the byte this cycle
// master = byte source, slave = transmitter.
interface hi_flite_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/hi_flite_tx.sv
// hi_flite_tx: reader-side ISO/IEC 18092 (FeliCa) frame transmitter.
// Sends PREAMBLE_BYTES x 0x00, sync B2 4D, the payload bytes and a CRC-16
// (poly 0x1021, init 0), Manchester-encoded at fc/64 or fc/32.
// Ports:
//   ck_1356meg : 13.56 MHz carrier clock, all logic on rising edge
//   rst        : synchronous active-high reset
//   speed      : 0 = 64 cycles/bit, 1 = 32 cycles/bit (latched at start)
//   start      : single-cycle frame request, honoured only when idle
//   tx         : payload byte handshake (slave side)
//   mod        : 1 = carrier modulated
//   busy       : frame in progress
//   done       : one-cycle pulse after the last CRC bit
//   underrun   : one-cycle pulse when a frame is aborted for late data
module hi_flite_tx #(
  parameter int unsigned PREAMBLE_BYTES = 6
) (
  input  logic          ck_1356meg,
  input  logic          rst,
  input  logic          speed,
  input  logic          start,
  hi_flite_tx_if.slave  tx,
  output logic          mod,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SYNC = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CRC  = 3'd4;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_last_q, hold_last_d;
  logic        hold_full_q, hold_full_d;
  logic        cur_last_q, cur_last_d;
  logic        last_acc_q, last_acc_d;
  logic [15:0] crc_q, crc_d;
  logic        speed_q, speed_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;

  logic [5:0]  tick_max;
  logic [5:0]  half;
  logic        bit_end;
  logic        byte_end;
  logic        hold_load;
  logic        xfer;
  logic [15:0] crc_step;

  assign tick_max = speed_q ? 6'd31 : 6'd63;
  assign half     = speed_q ? 6'd16 : 6'd32;
  assign busy     = (state_q != ST_IDLE);
  assign bit_end  = busy && (tick_q == tick_max);
  assign byte_end = bit_end && (bit_q == 3'd7);

  // Load points that draw from the holding register: end of 0x4D and end
  // of every non-final payload byte.
  assign hold_load = byte_end &&
                     (((state_q == ST_SYNC) && (cnt_q == 8'd1)) ||
                      ((state_q == ST_DATA) && !cur_last_q));

  // Ready also while full on a load cycle, so a waiting byte can be
  // replaced in the same cycle the old one moves to the shift register.
  assign tx.tx_ready = ((state_q == ST_SYNC) || (state_q == ST_DATA)) &&
                       !last_acc_q && (!hold_full_q || hold_load);
  assign xfer = tx.tx_valid && tx.tx_ready;

  // CRC advanced by the bit currently on air.
  assign crc_step = {crc_q[14:0], 1'b0} ^
                    ((crc_q[15] ^ shreg_q[7]) ? 16'h1021 : 16'h0000);

  assign mod      = busy && ((tick_q < half) ? shreg_q[7] : ~shreg_q[7]);
  assign done     = done_q;
  assign underrun = underrun_q;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    cur_last_d  = cur_last_q;
    last_acc_d  = last_acc_q;
    crc_d       = crc_q;
    speed_d     = speed_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;

    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d     = ST_PRE;
        tick_d      = '0;
        bit_d       = '0;
        cnt_d       = '0;
        shreg_d     = '0;
        crc_d       = '0;
        speed_d     = speed;
        hold_full_d = 1'b0;
        cur_last_d  = 1'b0;
        last_acc_d  = 1'b0;
      end
    end else begin
      if (xfer) begin
        hold_d      = tx.tx_data;
        hold_last_d = tx.tx_last;
        hold_full_d = 1'b1;
        if (tx.tx_last) last_acc_d = 1'b1;
      end

      if (bit_end) begin
        tick_d = '0;
        bit_d  = bit_q + 3'd1;
        if (state_q == ST_DATA) crc_d = crc_step;
        if (!byte_end) shreg_d = {shreg_q[6:0], 1'b0};
      end else begin
        tick_d = tick_q + 6'd1;
      end

      if (byte_end) begin
        if (hold_load) begin
          if (hold_full_q) begin
            shreg_d    = hold_q;
            cur_last_d = hold_last_q;
            if (!xfer) hold_full_d = 1'b0;
            state_d    = ST_DATA;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          case (state_q)
            ST_PRE: begin
              if (cnt_q == PRE_LAST) begin
                state_d = ST_SYNC;
                cnt_d   = '0;
                shreg_d = 8'hB2;
              end else begin
                cnt_d   = cnt_q + 8'd1;
                shreg_d = '0;
              end
            end
            ST_SYNC: begin
              shreg_d = 8'h4D;
              cnt_d   = 8'd1;
            end
            ST_DATA: begin
              // Final payload bit just folded in: crc_step is the final CRC.
              state_d = ST_CRC;
              cnt_d   = '0;
              shreg_d = crc_step[15:8];
            end
            ST_CRC: begin
              if (cnt_q == 8'd0) begin
                shreg_d = crc_q[7:0];
                cnt_d   = 8'd1;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      cur_last_q  <= 1'b0;
      last_acc_q  <= 1'b0;
      crc_q       <= '0;
      speed_q     <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      cur_last_q  <= cur_last_d;
      last_acc_q  <= last_acc_d;
      crc_q       <= crc_d;
      speed_q     <= speed_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_hi_flite_tx.sv
// Bench for hi_flite_tx: stimulus pushes each frame's expected bit stream
// into a scoreboard; a monitor checks mod cycle by cycle against it.
module tb_hi_flite_tx;
  localparam int unsigned PB = 6;

  logic clk = 1'b0;
  logic rst, speed, start;
  logic mod, busy, done, underrun;

  hi_flite_tx_if txif();

  hi_flite_tx #(.PREAMBLE_BYTES(PB)) dut (
    .ck_1356meg(clk),
    .rst       (rst),
    .speed     (speed),
    .start     (start),
    .tx        (txif),
    .mod       (mod),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // kind: 0 = completes with done, 1 = underrun abort, 2 = reset abort
  typedef struct {
    int nbits;
    int ncycles;
    int period;
    int kind;
    bit gapless;
  } frame_t;

  frame_t     fq[$];
  bit         eb[$];
  logic [7:0] pl[$];
  bit         mon_busy = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) eb.push_back(b[i]);
  endtask

  // Reference: whole frame as a bit list, CRC computed byte-wise.
  task automatic model_frame(input int period, input int kind, input bit gapless);
    logic [15:0] crc;
    int nb;
    frame_t f;
    crc = 16'h0000;
    for (int i = 0; i < int'(PB) * 8; i++) eb.push_back(1'b0);
    push_byte(8'hB2);
    push_byte(8'h4D);
    if (kind == 1) begin
      push_byte(pl[0]);
      nb = (int'(PB) + 3) * 8;
    end else begin
      for (int i = 0; i < pl.size(); i++) begin
        push_byte(pl[i]);
        crc = crc ^ {pl[i], 8'h00};
        for (int k = 0; k < 8; k++)
          crc = crc[15] ? ({crc[14:0], 1'b0} ^ 16'h1021) : {crc[14:0], 1'b0};
      end
      push_byte(crc[15:8]);
      push_byte(crc[7:0]);
      nb = (int'(PB) + 4 + pl.size()) * 8;
    end
    f.nbits = nb; f.ncycles = nb * period; f.period = period;
    f.kind = kind; f.gapless = gapless;
    fq.push_back(f);
  endtask

  // Monitor: waits for busy, checks each bit's Manchester waveform, then
  // the frame-end outputs.
  initial begin
    frame_t f;
    bit     bits[];
    int     cnt, errs, bi, tk;
    bit     stray, expm;
    forever begin
      while (fq.size() == 0) @(negedge clk);
      f = fq.pop_front();
      mon_busy = 1'b1;
      bits = new[f.nbits];
      for (int i = 0; i < f.nbits; i++) bits[i] = eb.pop_front();
      cnt = 0; stray = 1'b0;
      do begin
        @(negedge clk);
        cnt++;
        if (done) stray = 1'b1;
      end while (!busy && cnt < 20000);
      check("no stray done", stray, 0);
      if (!busy) begin
        check("busy rise timeout", busy, 1);
        summary();
      end
      if (f.gapless) check("gapless restart", cnt, 1);
      errs = 0;
      for (int c = 0; c < f.ncycles; c++) begin
        if (c > 0) @(negedge clk);
        bi = c / f.period;
        tk = c % f.period;
        expm = (tk < f.period / 2) ? bits[bi] : !bits[bi];
        if (mod != expm || !busy) errs++;
        if (tk == f.period - 1 || c == f.ncycles - 1) begin
          check($sformatf("bit %0d mod/busy errcycles", bi), errs, 0);
          errs = 0;
        end
      end
      @(negedge clk);
      case (f.kind)
        0: begin
          check("done pulse", done, 1);
          check("busy after done", busy, 0);
          check("mod after done", mod, 0);
          check("no underrun", underrun, 0);
        end
        1: begin
          check("underrun pulse", underrun, 1);
          check("no done on underrun", done, 0);
          check("busy after underrun", busy, 0);
          check("mod after underrun", mod, 0);
        end
        default: begin
          check("mod after rst", mod, 0);
          check("busy after rst", busy, 0);
          check("tx_ready after rst", txif.tx_ready, 0);
        end
      endcase
      mon_busy = 1'b0;
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 20000) begin @(negedge clk); k++; end
    if (busy) begin check("idle timeout", busy, 0); summary(); end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while (!done && k < 20000) begin @(negedge clk); k++; end
    if (!done) begin check("done timeout", done, 1); summary(); end
  endtask

  // Issues one frame; speed and start are scrambled while it runs.
  task automatic run_frame(input bit spd, input int kind, input bit b2b);
    int per, n, gap, k;
    per = spd ? 32 : 64;
    model_frame(per, kind, b2b);
    if (b2b) wait_done(); else wait_idle();
    speed = spd;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    speed = 1'($urandom);
    if (kind == 2) begin
      repeat (999) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    n = (kind == 1) ? 1 : pl.size();
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, per);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1 start = ($urandom_range(0, 15) == 0);
        speed = 1'($urandom);
      end
      start = 1'b0;
      txif.tx_data  = pl[i];
      txif.tx_last  = (kind == 0) && (i == n - 1);
      txif.tx_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!txif.tx_ready && k < 6000) begin @(negedge clk); k++; end
      check("handshake in budget", txif.tx_ready, 1);
      @(posedge clk);
      #1 txif.tx_valid = 1'b0;
      txif.tx_last = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    check("watchdog", 0, 1);
    summary();
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; speed = 1'b0;
    txif.tx_valid = 1'b0; txif.tx_data = '0; txif.tx_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mod", mod, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset underrun", underrun, 0);
    check("reset tx_ready", txif.tx_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    pl = '{8'h01};
    run_frame(1'b0, 0, 1'b0);

    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(1'b1, 0, 1'b0);

    pl = '{8'h05};
    run_frame(1'b0, 1, 1'b0);

    pl = '{8'h00};
    for (int i = 0; i < 16; i++) eb.push_back(1'b0);
    fq.push_back('{16, 1000, 64, 2, 1'b0});
    run_frame(1'b0, 2, 1'b0);
    // run_frame pushed its own descriptor too; drop that one (kind 2 uses
    // the hand-built 1000-cycle descriptor above).
    void'(fq.pop_back());
    for (int i = 0; i < (int'(PB) + 5) * 8; i++) void'(eb.pop_back());

    pl = '{8'(3), 8'hA5, 8'h5A};
    run_frame(1'b0, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      pl.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) pl.push_back(8'($urandom));
      run_frame(1'($urandom), 0, 1'b0);
    end

    pl = '{8'h03, 8'hDE, 8'hAD};
    run_frame(1'b1, 0, 1'b0);
    pl = '{8'h02, 8'hBE};
    run_frame(1'b1, 0, 1'b1);

    k = 0;
    while ((fq.size() != 0 || mon_busy) && k < 30000) begin @(negedge clk); k++; end
    check("scoreboard drained", fq.size() + int'(mon_busy), 0);
    summary();
  end

endmodule

// File: doc/hi_flite_tx.md
# hi_flite_tx

Reader-side ISO/IEC 18092 (FeliCa / NFC Type 3) frame transmitter, clocked from the 13.56 MHz carrier. It takes payload bytes from the ARM-side byte source over a valid/ready handshake. It generates the preamble and the B24D sync word, appends CRC-16, and Manchester-encodes the frame at 212 kbit/s (fc/64) or 424 kbit/s (fc/32). Its `mod` output drives the reader carrier-modulation path; it is the counterpart of the tag-side FeliCa demodulator/modulator.

## Interface
- `PREAMBLE_BYTES`, default 6: number of 0x00 preamble bytes sent before sync.
- `ck_1356meg` input, 1 bit: 13.56 MHz carrier clock; the only clock, all logic on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `speed` input, 1 bit: 0 selects 212 kbit/s (64 cycles/bit), 1 selects 424 kbit/s (32 cycles/bit). Sampled only when `start` is accepted.
- `start` input, 1 bit: single-cycle request to begin a frame.
- `tx_data` input, 8 bits: payload byte, length byte first, sent MSB first.
- `tx_valid` input, 1 bit: `tx_data`/`tx_last` valid.
- `tx_last` input, 1 bit: marks the final payload byte.
- `tx_ready` output, 1 bit: holding register empty and a byte is accepted this cycle.
- `mod` output, 1 bit: 1 means carrier modulated (field reduced).
- `busy` output, 1 bit: frame in progress.
- `done` output, 1 bit: one-cycle pulse after the last CRC bit completes.
- `underrun` output, 1 bit: one-cycle pulse when a frame is aborted because data was late.

## Operation
- Reset values: `mod`=0, `tx_ready`=0, `busy`=0, `done`=0, `underrun`=0. The state machine goes to IDLE, the holding register is emptied and the CRC is cleared.
- States and transitions:
  - IDLE: waits for `start`; goes to PREAMBLE.
  - PREAMBLE: sends `PREAMBLE_BYTES`×8 zero bits; goes to SYNC.
  - SYNC: sends 0xB2 then 0x4D; goes to DATA.
  - DATA: sends payload bytes; goes to CRC once the byte flagged `tx_last` finishes.
  - CRC: sends the CRC high byte then the low byte; goes to IDLE.
- `start` is accepted only in IDLE. In other states it is ignored. Accepting `start` latches `speed`.
- Bit timer `tick` counts 0..P−1, with P=64 (speed 0) or 32 (speed 1). A bit ends at tick P−1.
- Manchester rule for bit b: `mod`=b while tick < P/2, and `mod`=~b while tick ≥ P/2. A zero bit is unmodulated in the first half and modulated in the second.
- Data path: an 8-bit shift register sends MSB first, backed by a one-byte holding register (data + last flag).
- `tx_ready`=1 when state ∈ {SYNC, DATA}, the holding register is empty, and `tx_last` has not yet been accepted in this frame.
- A transfer occurs when `tx_valid`&&`tx_ready`.
- Byte load: at tick P−1 of bit 7 of the current byte, the shift register loads the next byte.
  - Leaving SYNC or DATA: loads from the holding register, which becomes empty the same cycle.
  - Leaving DATA after the last byte: loads the CRC high byte; the low byte follows.
- Underrun: the holding register is empty at a load point in SYNC/DATA. Then:
  - `underrun` pulses;
  - `mod`=0 from the next cycle;
  - state goes to IDLE and `done` is not asserted.
- CRC-16: polynomial 0x1021, init 0x0000, no reflection, no final XOR. It covers every accepted payload byte, the length byte included. It is updated bitwise as each DATA bit is shifted out, so it is final at the DATA→CRC load.
- After IDLE is entered, `mod`=0.

## Timing
- `start` accepted at cycle t: `busy`=1 and `mod` shows the first half of preamble bit 0 (0) from t+1; tick=0 at t+1.
- Frame length for N payload bytes: (PREAMBLE_BYTES+2+N+2)×8×P cycles, counted from t+1.
- `done`=1 for exactly one cycle, on the cycle after tick P−1 of the final CRC bit. `busy`=0 and `mod`=0 on that same cycle.
- A new `start` is accepted on the `done` cycle, so back-to-back frames are allowed.
- The first `tx_ready` assertion is the first SYNC cycle. The byte must be accepted before the SYNC→DATA load point (16×P cycles later).
- `rst` asserted mid-frame: outputs take their reset values on the next cycle and any partial frame is discarded.
- `tx_valid` and `tx_ready` both high on the load cycle: the new byte is captured into the holding register and the previous content moves to the shift register. This is legal and is not an underrun.

## Test plan
- Payload 0x01 (tx_last), speed 0, PREAMBLE_BYTES=6 → 6×8 zero bits (`mod` 0 for 32 cycles then 1 for 32), then B2 4D 01, then CRC 0x1021 (bytes 10 21). `done` lands exactly 11×8×64 cycles after start+1.
- Payload ASCII "123456789" (9 bytes), speed 1 → CRC bytes 31 C3; each bit is 32 cycles, with a 16/16 Manchester split.
- Source holds `tx_valid` low for a full byte time after the length byte 0x05 → `underrun` pulses at that byte's load point, `mod`=0 from the next cycle, `done` stays 0, `busy` falls.
- `rst` pulsed 1000 cycles into a frame → next cycle `mod`=0, `busy`=0, `tx_ready`=0. A following `start` produces a clean full preamble.
- `start` re-asserted mid-frame, and `speed` toggled mid-frame → both ignored; bit period unchanged; frame identical to a reference run.
- Two frames with `start` issued on the `done` cycle → second preamble starts on the next cycle with no gap; the CRC is reset (the second frame's CRC matches a standalone run).
